// File: rtl/clock_reset_manager.sv
`default_nettype none
// ============================================================================
// Module   : clock_reset_manager
// Purpose  : Generates NUM_CH clock-enable / divided-clock channels with
//            run-time programmable divisors. Also releases per-channel resets
//            in a staggered sequence after power-on or a soft reset request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   div_i       in   requested divisors, channel i at [i*DIV_WIDTH +: DIV_WIDTH]
//   div_load_i  in   per-channel strobe capturing div_i into a shadow register
//   soft_rst_i  in   synchronous restart of the sequencer and all dividers
//   en_o        out  one-cycle enable, once per divisor period
//   div_clk_o   out  registered divided clock (high for ceil(D/2) cycles)
//   rst_o       out  active-high channel resets
//   done_o      out  all channel resets released
// ============================================================================
module clock_reset_manager #(
  parameter int NUM_CH         = 2,
  parameter int DIV_WIDTH      = 8,
  parameter int DEFAULT_DIV    = 2,
  parameter int RESET_CYCLES   = 20,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*DIV_WIDTH-1:0]   div_i,
  input  logic [NUM_CH-1:0]             div_load_i,
  input  logic                          soft_rst_i,
  output logic [NUM_CH-1:0]             en_o,
  output logic [NUM_CH-1:0]             div_clk_o,
  output logic [NUM_CH-1:0]             rst_o,
  output logic                          done_o
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV_C = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE_C     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0]   ONE_W_C   = {{DIV_WIDTH{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Divider channels
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_WIDTH-1:0] active_q, active_d;
      logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic                 pending_q, pending_d;
      logic                 en_q, en_d;
      logic                 dclk_q, dclk_d;
      logic [DIV_WIDTH-1:0] div_eff;
      logic [DIV_WIDTH-1:0] div_in;
      logic [DIV_WIDTH:0]   half;
      logic                 wrap;

      assign div_in = div_i[gi*DIV_WIDTH +: DIV_WIDTH];

      always_comb begin
        // 0 and 1 both mean divide-by-1
        div_eff   = (active_q == '0) ? ONE_C : active_q;
        half      = ({1'b0, div_eff} + ONE_W_C) >> 1;
        wrap      = (cnt_q >= div_eff - ONE_C);
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        en_d      = 1'b0;
        dclk_d    = 1'b0;
        if (soft_rst_i) begin
          // A load on the same edge wins over an older pending value.
          if (div_load_i[gi]) begin
            active_d = div_in;
            shadow_d = div_in;
          end else if (pending_q) begin
            active_d = shadow_q;
          end
          pending_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = wrap ? '0 : cnt_q + ONE_C;
          // New divisor only takes effect at a wrap, so periods stay whole.
          // The outputs on the wrap edge are 1/1 for any divisor, so the old
          // half-period threshold is safe to use below.
          if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
          if (div_load_i[gi]) begin
            shadow_d  = div_in;
            pending_d = 1'b1;
          end
          en_d   = (cnt_d == '0);
          dclk_d = ({1'b0, cnt_d} < half);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          active_q  <= DEF_DIV_C;
          shadow_q  <= DEF_DIV_C;
          pending_q <= 1'b0;
          cnt_q     <= '0;
          en_q      <= 1'b0;
          dclk_q    <= 1'b0;
        end else begin
          active_q  <= active_d;
          shadow_q  <= shadow_d;
          pending_q <= pending_d;
          cnt_q     <= cnt_d;
          en_q      <= en_d;
          dclk_q    <= dclk_d;
        end
      end

      assign en_o[gi]      = en_q;
      assign div_clk_o[gi] = dclk_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Reset sequencer
  // --------------------------------------------------------------------------
  localparam int SEQ_MAX = RESET_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX < 2) ? 1 : $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] SEQ_MAX_C = SEQ_W'(SEQ_MAX);
  localparam logic [SEQ_W-1:0] REL0_C    = SEQ_W'(RESET_CYCLES);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t              state_q;
  logic [SEQ_W-1:0]    seq_q;
  logic [SEQ_W-1:0]    seq_d;
  logic [NUM_CH-1:0]   rst_q;
  logic                done_q;

  // seq_d is the count after this edge; outputs are flopped from it so that
  // rst_o[i] falls exactly after edge RESET_CYCLES + i*STAGGER_CYCLES.
  assign seq_d = (seq_q >= SEQ_MAX_C) ? seq_q : seq_q + SEQ_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      seq_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else if (soft_rst_i) begin
      state_q <= S_HOLD;
      seq_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      seq_q <= seq_d;
      case (state_q)
        S_HOLD: begin
          if (seq_d >= REL0_C) begin
            // With one channel or no stagger, everything releases at once.
            state_q <= (seq_d >= SEQ_MAX_C) ? S_RUN : S_STAGGER;
          end
        end
        S_STAGGER: begin
          if (seq_d >= SEQ_MAX_C) state_q <= S_RUN;
        end
        S_RUN:   state_q <= S_RUN;
        default: state_q <= S_HOLD;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (seq_d >= SEQ_W'(RESET_CYCLES + i * STAGGER_CYCLES)) rst_q[i] <= 1'b0;
      end
      done_q <= (seq_d >= SEQ_MAX_C);
    end
  end

  assign rst_o  = rst_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_reset_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_reset_manager
// Purpose  : Directed self-checking bench for clock_reset_manager. A default
//            instance (2 channels) covers sequencing, divisor loads and soft /
//            hard resets; a 4-channel instance with RESET_CYCLES=1 and no
//            stagger covers the simultaneous-release corner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_reset_manager;

  logic        clk;
  logic        rst_n;
  logic [15:0] div_i;
  logic [1:0]  div_load_i;
  logic        soft_rst_i;
  logic [1:0]  en_o, div_clk_o, rst_o;
  logic        done_o;

  logic [31:0] div2_i;
  logic [3:0]  div_load2_i;
  logic        soft_rst2_i;
  logic [3:0]  en2_o, div_clk2_o, rst2_o;
  logic        done2_o;

  int tests_run;
  int tests_failed;
  int ek;

  clock_reset_manager dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .soft_rst_i (soft_rst_i),
    .en_o       (en_o),
    .div_clk_o  (div_clk_o),
    .rst_o      (rst_o),
    .done_o     (done_o)
  );

  clock_reset_manager #(
    .NUM_CH         (4),
    .DIV_WIDTH      (8),
    .DEFAULT_DIV    (2),
    .RESET_CYCLES   (1),
    .STAGGER_CYCLES (0)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_i      (div2_i),
    .div_load_i (div_load2_i),
    .soft_rst_i (soft_rst2_i),
    .en_o       (en2_o),
    .div_clk_o  (div_clk2_o),
    .rst_o      (rst2_o),
    .done_o     (done2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s (edge %0d): got %0h expected %0h", tag, ek, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ek++;
  endtask

  // Expected outputs of one channel whose counter is cnt with effective divisor d.
  task automatic exp_ch(input int ch, input int cnt, input int d);
    logic e_en, e_dclk;
    e_en   = (cnt == 0);
    e_dclk = (cnt < (d + 1) / 2);
    check($sformatf("en_o[%0d]", ch), {31'd0, en_o[ch]}, {31'd0, e_en});
    check($sformatf("div_clk_o[%0d]", ch), {31'd0, div_clk_o[ch]}, {31'd0, e_dclk});
  endtask

  // Default sequencing: rst_o[0] low from edge 20, rst_o[1]/done_o from edge 24.
  task automatic exp_seq(input int k);
    logic [1:0] e_rst;
    e_rst = {(k < 24), (k < 20)};
    check("rst_o", {30'd0, rst_o}, {30'd0, e_rst});
    check("done_o", {31'd0, done_o}, {31'd0, (k >= 24)});
  endtask

  task automatic check_reset_state();
    check("rst_o reset", {30'd0, rst_o}, 32'h3);
    check("done_o reset", {31'd0, done_o}, 32'h0);
    check("en_o reset", {30'd0, en_o}, 32'h0);
    check("div_clk_o reset", {30'd0, div_clk_o}, 32'h0);
    check("dut2 rst_o reset", {28'd0, rst2_o}, 32'hF);
    check("dut2 done_o reset", {31'd0, done2_o}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ek           = 0;
    rst_n        = 1'b0;
    div_i        = '0;
    div_load_i   = '0;
    soft_rst_i   = 1'b0;
    div2_i       = '0;
    div_load2_i  = '0;
    soft_rst2_i  = 1'b0;

    // Reset state while clocks run
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();

    // Power-on sequence with default divisors
    rst_n = 1'b1;
    ek    = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp_seq(ek);
      exp_ch(0, ek % 2, 2);
      exp_ch(1, ek % 2, 2);
      if (ek == 1) begin
        check("dut2 rst_o edge1", {28'd0, rst2_o}, 32'h0);
        check("dut2 done_o edge1", {31'd0, done2_o}, 32'h1);
      end
    end

    // Divisor 5 on ch0 loaded mid-period; wrap at edge 28 applies it
    div_i[7:0] = 8'd5;
    div_load_i = 2'b01;
    tick();                                   // edge 27
    div_load_i = 2'b00;
    exp_ch(0, 1, 2);
    exp_ch(1, ek % 2, 2);
    for (int k = 28; k <= 38; k++) begin
      tick();
      exp_ch(0, (ek - 28) % 5, 5);
      exp_ch(1, ek % 2, 2);
    end

    // Loads of 7 then 9 before the wrap: 9 wins at edge 43
    div_i[7:0] = 8'd7;
    div_load_i = 2'b01;
    tick();                                   // edge 39
    exp_ch(0, 1, 5);
    div_i[7:0] = 8'd9;
    tick();                                   // edge 40
    div_load_i = 2'b00;
    exp_ch(0, 2, 5);
    for (int k = 41; k <= 52; k++) begin
      tick();
      if (ek < 43) exp_ch(0, ek - 38, 5);
      else         exp_ch(0, (ek - 43) % 9, 9);
      exp_ch(1, ek % 2, 2);
    end

    // Divisor 0 (divide-by-1) applied at the wrap on edge 61
    div_i[7:0] = 8'd0;
    div_load_i = 2'b01;
    tick();                                   // edge 53
    div_load_i = 2'b00;
    exp_ch(0, 1, 9);
    for (int k = 54; k <= 64; k++) begin
      tick();
      if (ek < 61) exp_ch(0, ek - 52, 9);
      else         exp_ch(0, 0, 1);
      exp_ch(1, ek % 2, 2);
    end

    // Divisor 1 keeps outputs constant high
    div_i[7:0] = 8'd1;
    div_load_i = 2'b01;
    tick();                                   // edge 65
    div_load_i = 2'b00;
    exp_ch(0, 0, 1);
    for (int k = 66; k <= 68; k++) begin
      tick();
      exp_ch(0, 0, 1);
      exp_ch(1, ek % 2, 2);
    end
    check("done_o held in RUN", {31'd0, done_o}, 32'h1);

    // Soft reset in RUN, with a simultaneous load of 3 on ch1
    soft_rst_i  = 1'b1;
    div_i[15:8] = 8'd3;
    div_load_i  = 2'b10;
    tick();
    soft_rst_i = 1'b0;
    div_load_i = 2'b00;
    ek         = 0;
    check("rst_o after soft", {30'd0, rst_o}, 32'h3);
    check("done_o after soft", {31'd0, done_o}, 32'h0);
    check("en_o after soft", {30'd0, en_o}, 32'h0);
    check("div_clk_o after soft", {30'd0, div_clk_o}, 32'h0);
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_seq(ek);
      exp_ch(0, 0, 1);
      exp_ch(1, ek % 3, 3);
    end

    // Hard reset during STAGGER (after edge 22)
    soft_rst_i = 1'b1;
    tick();
    soft_rst_i = 1'b0;
    ek         = 0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (ek >= 20) exp_seq(ek);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ek    = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      exp_seq(ek);
      exp_ch(0, ek % 2, 2);
      exp_ch(1, ek % 2, 2);
      if (ek == 1) begin
        check("dut2 rst_o restart", {28'd0, rst2_o}, 32'h0);
        check("dut2 done_o restart", {31'd0, done2_o}, 32'h1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_reset_manager.md
# clock_reset_manager

Parametrised clock-enable and reset sequencer that generalises the board-level divide-by-two and fixed-hold reset used in FPGA top-levels. It generates NUM_CH independent clock-enable/divided-clock channels with run-time-programmable divisors, and per-channel active-high resets released in a staggered sequence after power-on or a soft reset request. It sits between the board clock/reset pins and the Controller/processor core instances.

## Interface
- NUM_CH, 2: number of output channels (1..8)
- DIV_WIDTH, 8: divisor width per channel
- DEFAULT_DIV, 2: divisor loaded into every channel at reset
- RESET_CYCLES, 20: cycles all rst_o stay asserted after reset release (>=1)
- STAGGER_CYCLES, 4: extra cycles between release of channel i and channel i+1
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- div_i  in  NUM_CH*DIV_WIDTH  requested divisor, channel i at bits [i*DIV_WIDTH +: DIV_WIDTH]
- div_load_i  in  NUM_CH  capture div_i slice of channel i into shadow register
- soft_rst_i  in  1  synchronous restart of sequencer and all dividers
- en_o  out  NUM_CH  one-cycle clock enable, once per divisor period
- div_clk_o  out  NUM_CH  registered divided clock
- rst_o  out  NUM_CH  active-high channel reset
- done_o  out  1  all channel resets released

## Operation
- Effective divisor D = max(active_div, 1); values 0 and 1 both mean divide-by-1.
- Per channel: counter cnt in 0..D-1; each edge cnt <= (cnt >= D-1) ? 0 : cnt+1. en_o and div_clk_o are flops loaded from the next count: en_o = (cnt_next == 0), div_clk_o = (cnt_next < ceil(D/2)).
- D=1: en_o and div_clk_o constant 1 after the first edge. D=3: div_clk_o high 2 of every 3 cycles.
- div_load_i[i] high at an edge: shadow[i] <= div_i slice, pending[i] <= 1. A repeated load before apply overwrites shadow (last value wins).
- Pending divisor applied at the edge where cnt wraps to 0: active_div <= shadow, pending cleared; the new period starts from that wrap. No truncated or stretched period ever appears on div_clk_o.
- Sequencer FSM: HOLD -> STAGGER -> RUN.
  - seq_cnt increments every edge from 0, saturating at RESET_CYCLES+(NUM_CH-1)*STAGGER_CYCLES.
  - HOLD: all rst_o = 1; leave when seq_cnt reaches RESET_CYCLES.
  - STAGGER: rst_o[i] <= 0 once seq_cnt >= RESET_CYCLES + i*STAGGER_CYCLES; go to RUN when the last channel releases.
  - RUN: done_o = 1; remains until soft_rst_i or rst_n.
- soft_rst_i high at an edge (any state): state <= HOLD, seq_cnt <= 0, all rst_o <= 1, done_o <= 0; every cnt <= 0, en_o <= 0, div_clk_o <= 0; pending divisors applied immediately. Dividers then run phase-aligned to the new sequence.
- soft_rst_i and div_load_i in the same edge: the load is captured and applied immediately by the soft reset.
- STAGGER_CYCLES = 0: all channels release on the same edge.

## Timing
- Reset values: en_o = 0, div_clk_o = 0, rst_o = all 1, done_o = 0, cnt = 0, seq_cnt = 0, active_div = shadow = DEFAULT_DIV, pending = 0, state HOLD.
- Edge k = k-th rising edge after rst_n deasserts (or after the edge that sampled soft_rst_i).
- After edge k: cnt = k mod D; en_o high after edges D, 2D, ...
- rst_o[i] low after edge RESET_CYCLES + i*STAGGER_CYCLES.
- done_o rises on the same edge as the last channel's release.
- div_load_i to active: from 1 cycle (load at the edge before a wrap) up to D_old cycles.
- rst_n assertion clears all state asynchronously, mid-sequence or mid-period included.

## Test plan
- Defaults, NUM_CH=2: release rst_n -> rst_o[0] falls after edge 20, rst_o[1] and done_o after edge 24; en_o pulses every 2 cycles; div_clk_o alternates 1/0.
- Divisor 5 loaded on ch0 mid-period of D=2 -> current 2-cycle period completes; then en_o every 5 cycles; div_clk_o 3 high / 2 low; ch1 unaffected.
- div_i = 0 and then 1 -> en_o and div_clk_o constant 1; loads of 7 then 9 before the wrap -> 9 applied.
- soft_rst_i pulse in RUN -> next cycle rst_o = 2'b11, done_o = 0, en_o = 0; sequence repeats with identical 20/24 edge timing.
- rst_n asserted during STAGGER (after edge 22) -> all outputs at reset values immediately; full sequence restarts on release.
- NUM_CH=4, STAGGER_CYCLES=0, RESET_CYCLES=1 -> all rst_o and done_o fall after edge 1.
